// File: rtl/bus_arbiter_n_pkg.sv
// Shared definitions for the N-master bus arbiter: mode codes, FSM encoding
// and the pointer-advance helper.
package bus_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    localparam int DEFAULT_NUM_MASTERS = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN  = 2'd1,
        ARB_GAP  = 2'd2
    } arb_state_e;

    // Next round-robin start position: one past the winner, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_n_if.sv
// Request/grant bundle between the master ports and the arbiter; the grant
// side also drives the shared address/data mux select.
interface bus_arbiter_n_if #(
    parameter int NUM_MASTERS = bus_pkg::DEFAULT_NUM_MASTERS
);
    localparam int IDW = $clog2(NUM_MASTERS);

    logic                   ena;
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] done;
    logic [NUM_MASTERS-1:0] grant;
    logic [IDW-1:0]         gnt_id;
    logic                   bus_busy;
    logic [NUM_MASTERS-1:0] m_busy;
    logic                   timeout_err;

    // Requesting side: the masters (or a bench standing in for them).
    modport master (
        output ena, req, done,
        input  grant, gnt_id, bus_busy, m_busy, timeout_err
    );

    // Arbitrating side.
    modport slave (
        input  ena, req, done,
        output grant, gnt_id, bus_busy, m_busy, timeout_err
    );

endinterface

// File: rtl/bus_arbiter_n_arb_pick.sv
// Combinational winner picker: rotate the request vector by the start
// pointer, find the first set bit, then rotate the index back.
module arb_pick #(
    parameter int NUM_MASTERS = bus_pkg::DEFAULT_NUM_MASTERS,
    parameter int IDW         = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDW-1:0]         rr_ptr,
    input  logic                   mode,
    output logic                   valid,
    output logic [NUM_MASTERS-1:0] winner,
    output logic [IDW-1:0]         winner_idx
);

    logic [IDW-1:0]         ptr_eff;
    logic [NUM_MASTERS-1:0] rot;
    logic [IDW-1:0]         first;
    logic [IDW:0]           sum;

    // Fixed priority is simply round robin with the start pinned at index 0.
    assign ptr_eff = mode ? rr_ptr : '0;

    // Doubling the vector turns the rotate into a plain right shift.
    assign rot = NUM_MASTERS'({req, req} >> ptr_eff);

    // NOTE: every always_comb output gets a default before any branch, so no
    //       path can leave it unassigned and infer a latch.
    always_comb begin
        first = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (rot[i]) first = IDW'(i);
        end
    end

    assign sum        = {1'b0, first} + {1'b0, ptr_eff};
    assign winner_idx = (sum >= (IDW + 1)'(NUM_MASTERS))
                        ? IDW'(sum - (IDW + 1)'(NUM_MASTERS))
                        : IDW'(sum);
    assign valid      = |req;
    assign winner     = valid ? (NUM_MASTERS'(1) << winner_idx) : '0;

endmodule

// File: rtl/bus_arbiter_n.sv
// N-master bus arbiter: IDLE/OWN/GAP tenure FSM with optional timeout,
// fixed-priority or round-robin selection, and registered one-hot grant.
module bus_arbiter_n
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS,
    parameter int MODE        = MODE_RR,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 8
) (
    input logic          clock,
    input logic          rst,
    bus_arbiter_n_if.slave bus
);

    localparam int IDW = $clog2(NUM_MASTERS);
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDW-1:0]         gnt_id_q, gnt_id_d;
    logic                   busy_q, busy_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDW-1:0]         ptr_q, ptr_d;
    logic                   terr_q, terr_d;

    logic                   pick_valid;
    logic [NUM_MASTERS-1:0] pick_oh;
    logic [IDW-1:0]         pick_idx;

    logic                   owner_done;
    logic                   owner_req;
    logic                   to_hit;
    logic                   normal_rel;

    arb_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDW         (IDW)
    ) u_pick (
        .req        (bus.req),
        .rr_ptr     (ptr_q),
        .mode       (MODE == MODE_RR),
        .valid      (pick_valid),
        .winner     (pick_oh),
        .winner_idx (pick_idx)
    );

    // Masking with the one-hot grant ignores done/req edges from non-owners.
    assign owner_done = |(bus.done & grant_q);
    assign owner_req  = |(bus.req  & grant_q);
    assign to_hit     = TO_EN && (cnt_q == TO_LAST);
    assign normal_rel = owner_done || !owner_req;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gnt_id_d = gnt_id_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        terr_d   = 1'b0;

        unique case (state_q)
            // GAP is the single dead cycle after a tenure; its exit edge
            // arbitrates exactly like IDLE so tenures are one cycle apart.
            ARB_IDLE, ARB_GAP: begin
                state_d  = ARB_IDLE;
                grant_d  = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
                cnt_d    = '0;
                if (bus.ena && pick_valid) begin
                    state_d  = ARB_OWN;
                    grant_d  = pick_oh;
                    gnt_id_d = pick_idx;
                    busy_d   = 1'b1;
                    if (MODE == MODE_RR) begin
                        ptr_d = IDW'(wrap_inc(int'(pick_idx), NUM_MASTERS));
                    end
                end
            end

            ARB_OWN: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                if (normal_rel || to_hit) begin
                    state_d  = ARB_GAP;
                    grant_d  = '0;
                    gnt_id_d = '0;
                    busy_d   = 1'b0;
                    cnt_d    = '0;
                    // A coincident done or req drop wins over the timeout.
                    terr_d   = to_hit && !normal_rel;
                end
            end

            default: begin
                state_d  = ARB_IDLE;
                grant_d  = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
                cnt_d    = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    //       register samples the pre-edge value of every other register.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            ptr_q    <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gnt_id_q <= gnt_id_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            terr_q   <= terr_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.gnt_id      = gnt_id_q;
    assign bus.bus_busy    = busy_q;
    assign bus.timeout_err = terr_q;
    assign bus.m_busy      = bus.req & {NUM_MASTERS{busy_q}} & ~grant_q;

endmodule

// File: doc/bus_arbiter_n.md
Name: bus_arbiter_n

Overview:
- Parametrised N-master system-bus arbiter; replaces the fixed two-master arbitration inside the bus top level.
- Accepts per-master requests and grants exactly one owner at a time.
- Supports fixed-priority or round-robin selection, a bounded tenure timeout and per-master busy indication.
- Sits between the master ports and the shared address/data mux; its grant vector drives the mux select.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8)
- MODE, 1, 0 = fixed priority (index 0 highest), 1 = round robin
- TIMEOUT, 255, max cycles a master may hold the bus; 0 disables the timeout
- CNT_W, 8, tenure counter width; must satisfy TIMEOUT < 2**CNT_W

Ports:
- clock  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- ena  in  1  arbitration enable; when low, no new grant is issued and a current owner keeps its grant
- req  in  NUM_MASTERS  per-master bus request, level
- done  in  NUM_MASTERS  per-master transaction-complete pulse
- grant  out  NUM_MASTERS  one-hot grant, registered
- gnt_id  out  $clog2(NUM_MASTERS)  index of the current owner; 0 when idle
- bus_busy  out  1  high while any grant is active
- m_busy  out  NUM_MASTERS  high for master i when req[i]=1 and another master owns the bus
- timeout_err  out  1  one-cycle pulse when a tenure is force-terminated

Behaviour:
- Reset (rst=0, async): every output is 0, state=IDLE, rr_ptr=0, tenure counter=0.
- States:
  - IDLE: no grant.
    - If ena=1 and |req, pick a winner, go to OWN. grant/gnt_id/bus_busy rise on the next edge, so request-to-grant latency is 1 cycle.
    - In MODE 1, rr_ptr <= winner+1, wrapping modulo NUM_MASTERS.
  - OWN: grant is held and the counter increments each cycle from 0 (first owned cycle = 0).
    - Release when done[owner]=1, or req[owner]=0, or (TIMEOUT!=0 and counter==TIMEOUT-1).
    - On release go to GAP.
  - GAP: one dead cycle with grant=0 and bus_busy=0, then return to IDLE and re-arbitrate. Back-to-back tenures are therefore separated by exactly one idle cycle.
- Winner selection:
  - MODE 0: lowest-index requesting master.
  - MODE 1: first requesting master at or after rr_ptr, searching upward with wrap.
- Timeout release pulses timeout_err for exactly the cycle entering GAP. A release by done or by dropping req does not pulse it.
- done and req edges from non-owners are ignored.
- ena=0 during OWN: tenure continues and the timeout still counts. ena=0 in IDLE: remain in IDLE.
- Simultaneous done[owner] and timeout: treat as a normal release, no timeout_err.
- m_busy is combinational from req and the registered grant: m_busy[i] = req[i] & bus_busy & ~grant[i].
- Reset asserted mid-tenure: grant drops immediately (async) and the pointer returns to 0.
- The counter saturates; it never wraps inside a tenure.

Decomposition:
- Shared package bus_pkg holds:
  - MODE_FIXED=0, MODE_RR=1
  - state encoding ARB_IDLE, ARB_OWN, ARB_GAP (2-bit)
  - the default NUM_MASTERS
- One sub-module, arb_pick: combinational priority picker.
  - Inputs: req, rr_ptr, mode.
  - Outputs: valid, one-hot winner, winner index.
  - Uses a double-width rotate-and-find-first scheme.
- FSM, counter and output registers live in bus_arbiter_n.

Test Plan (NUM_MASTERS=4, TIMEOUT=16):
- Reset with req=4'b1111 held; release rst -> all outputs 0 during reset. In MODE 0, grant=4'b0001 and gnt_id=0 one cycle after release; m_busy=4'b1110.
- MODE 1, req=4'b1111 held constant, each owner pulses done after 3 cycles -> grant sequence 0001,0010,0100,1000,0001 with exactly one grant=0 cycle between tenures.
- MODE 0, master 2 holds req for 40 cycles with no done -> grant=4'b0100 for exactly 16 cycles, timeout_err high for 1 cycle, one gap cycle, then master 2 is re-granted.
- ena=0 with req=4'b0100 -> grant stays 0. Raise ena -> grant=4'b0100 next cycle. Drop ena mid-tenure -> grant is held until done.
- done[1] pulsed while master 0 owns -> no effect. done[0] on the same cycle the counter hits 15 -> release with timeout_err=0.
- Assert rst mid-tenure (owner 3) -> grant=0 asynchronously. After release with req=4'b1001 in MODE 1 -> master 0 is granted (pointer reset).
